sdmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the byte-addressed data memory (combinational read, posedge write).
- Port 0 is the scalar LSU; port 1 is the vector LSU.
- Grants at most one access per cycle using round-robin arbitration, with optional bounded bus locking for port 1 bursts.
- Drives the memory control, address and write data; returns registered read data to the winning requester.

---
 rtl/sdmem_arbiter_if.sv | 62 ++++++
 rtl/sdmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sdmem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdmem_arbiter_if.sv
// Requester-side bundle for sdmem_arbiter: port 0 (scalar LSU) and port 1 (vector LSU).
// Optional macro SDMEM_ARB_ALIGN_CHECK_EN adds the per-port pX_rsp_err_o pulse.
//
// Handshake: a request is accepted in a cycle where valid and ready are both high.
// Ready is combinational and may depend on valid. While valid is high and ready is
// low, the requester holds every request field stable. Responses come one cycle after
// acceptance as a single-cycle pulse and cannot be back-pressured.
interface sdmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  p0_valid_i;
    logic                  p0_ready_o;
    logic                  p0_we_i;
    logic [1:0]            p0_size_i;
    logic [DATA_WIDTH-1:0] p0_addr_i;
    logic [DATA_WIDTH-1:0] p0_wdata_i;
    logic                  p0_rsp_valid_o;
    logic [DATA_WIDTH-1:0] p0_rsp_rdata_o;

    logic                  p1_valid_i;
    logic                  p1_ready_o;
    logic                  p1_we_i;
    logic [1:0]            p1_size_i;
    logic [DATA_WIDTH-1:0] p1_addr_i;
    logic [DATA_WIDTH-1:0] p1_wdata_i;
    logic                  p1_rsp_valid_o;
    logic [DATA_WIDTH-1:0] p1_rsp_rdata_o;
    logic                  p1_lock_i;

`ifdef SDMEM_ARB_ALIGN_CHECK_EN
    logic                  p0_rsp_err_o;
    logic                  p1_rsp_err_o;

    modport master (
        output p0_valid_i, p0_we_i, p0_size_i, p0_addr_i, p0_wdata_i,
        input  p0_ready_o, p0_rsp_valid_o, p0_rsp_rdata_o, p0_rsp_err_o,
        output p1_valid_i, p1_we_i, p1_size_i, p1_addr_i, p1_wdata_i, p1_lock_i,
        input  p1_ready_o, p1_rsp_valid_o, p1_rsp_rdata_o, p1_rsp_err_o
    );

    modport slave (
        input  p0_valid_i, p0_we_i, p0_size_i, p0_addr_i, p0_wdata_i,
        output p0_ready_o, p0_rsp_valid_o, p0_rsp_rdata_o, p0_rsp_err_o,
        input  p1_valid_i, p1_we_i, p1_size_i, p1_addr_i, p1_wdata_i, p1_lock_i,
        output p1_ready_o, p1_rsp_valid_o, p1_rsp_rdata_o, p1_rsp_err_o
    );
`else
    modport master (
        output p0_valid_i, p0_we_i, p0_size_i, p0_addr_i, p0_wdata_i,
        input  p0_ready_o, p0_rsp_valid_o, p0_rsp_rdata_o,
        output p1_valid_i, p1_we_i, p1_size_i, p1_addr_i, p1_wdata_i, p1_lock_i,
        input  p1_ready_o, p1_rsp_valid_o, p1_rsp_rdata_o
    );

    modport slave (
        input  p0_valid_i, p0_we_i, p0_size_i, p0_addr_i, p0_wdata_i,
        output p0_ready_o, p0_rsp_valid_o, p0_rsp_rdata_o,
        input  p1_valid_i, p1_we_i, p1_size_i, p1_addr_i, p1_wdata_i, p1_lock_i,
        output p1_ready_o, p1_rsp_valid_o, p1_rsp_rdata_o
    );
`endif
endinterface

// File: rtl/sdmem_arbiter.sv
// sdmem_arbiter: round-robin arbiter/sequencer in front of the byte-addressed data memory.
// Port 0 is the scalar LSU, port 1 the vector LSU; port 1 may lock the bus for bounded bursts.
// Optional macro SDMEM_ARB_ALIGN_CHECK_EN: misaligned half/word accesses are accepted but not
// forwarded to memory, and answered with a pX_rsp_err_o pulse one cycle later.
// The FSM state is visible on locked_o (ARB = 0, LOCKED = 1).
module sdmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sdmem_arbiter_if.slave        bus,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [1:0]            mem_size_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  locked_o
);
    typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    state_t     state_q, state_d;
    logic       rr_q, rr_d;          // 0 = port 0 wins a tie, 1 = port 1 wins a tie
    logic [7:0] lock_cnt_q, lock_cnt_d;

    logic                  grant0, grant1;
    logic                  sel_we;
    logic [1:0]            sel_size;
    logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;
    logic                  misalign, forward;
    logic                  p0_rsp_valid_d, p1_rsp_valid_d;
    logic                  p0_rsp_valid_q, p1_rsp_valid_q;
    logic [DATA_WIDTH-1:0] p0_rsp_rdata_q, p1_rsp_rdata_q;
`ifdef SDMEM_ARB_ALIGN_CHECK_EN
    logic                  p0_rsp_err_d, p1_rsp_err_d;
    logic                  p0_rsp_err_q, p1_rsp_err_q;
`endif

    // State register: FSM state, round-robin pointer and lock counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            rr_q       <= 1'b0;
            lock_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Next-state logic: pointer moves away from the winner; port 1 may lock the bus.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (grant0) begin
                    rr_d = 1'b1;
                end else if (grant1) begin
                    rr_d = 1'b0;
                    // With MAX_LOCK = 1 the first locked grant already exhausts the budget.
                    if (bus.p1_lock_i && (MAX_LOCK_C > 8'd1)) begin
                        state_d    = ST_LOCKED;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (grant1) begin
                    if (!bus.p1_lock_i || ((lock_cnt_q + 8'd1) >= MAX_LOCK_C)) begin
                        state_d    = ST_ARB;
                        lock_cnt_d = 8'd0;
                        rr_d       = 1'b0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Output logic: grant selection, request mux and memory drive (all zero when idle or in reset).
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                grant1 = bus.p1_valid_i;
            end else if (bus.p0_valid_i && (!bus.p1_valid_i || !rr_q)) begin
                grant0 = 1'b1;
            end else begin
                grant1 = bus.p1_valid_i;
            end
        end

        sel_we    = grant1 ? bus.p1_we_i    : bus.p0_we_i;
        sel_size  = grant1 ? bus.p1_size_i  : bus.p0_size_i;
        sel_addr  = grant1 ? bus.p1_addr_i  : bus.p0_addr_i;
        sel_wdata = grant1 ? bus.p1_wdata_i : bus.p0_wdata_i;

        misalign = 1'b0;
`ifdef SDMEM_ARB_ALIGN_CHECK_EN
        misalign = ((sel_size == 2'b01) && sel_addr[0]) ||
                   (sel_size[1] && (sel_addr[1:0] != 2'b00));
`endif
        forward = (grant0 || grant1) && !misalign;

        mem_read_o  = forward && !sel_we;
        mem_write_o = forward && sel_we;
        mem_size_o  = forward ? sel_size  : 2'b00;
        mem_addr_o  = forward ? sel_addr  : '0;
        mem_wdata_o = forward ? sel_wdata : '0;

        p0_rsp_valid_d = grant0 && forward && !sel_we;
        p1_rsp_valid_d = grant1 && forward && !sel_we;
`ifdef SDMEM_ARB_ALIGN_CHECK_EN
        p0_rsp_err_d = grant0 && misalign;
        p1_rsp_err_d = grant1 && misalign;
`endif
    end

    // Response registers: capture read data at the end of the accept cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rsp_valid_q <= 1'b0;
            p1_rsp_valid_q <= 1'b0;
            p0_rsp_rdata_q <= '0;
            p1_rsp_rdata_q <= '0;
`ifdef SDMEM_ARB_ALIGN_CHECK_EN
            p0_rsp_err_q   <= 1'b0;
            p1_rsp_err_q   <= 1'b0;
`endif
        end else begin
            p0_rsp_valid_q <= p0_rsp_valid_d;
            p1_rsp_valid_q <= p1_rsp_valid_d;
            if (p0_rsp_valid_d) p0_rsp_rdata_q <= mem_rdata_i;
            if (p1_rsp_valid_d) p1_rsp_rdata_q <= mem_rdata_i;
`ifdef SDMEM_ARB_ALIGN_CHECK_EN
            p0_rsp_err_q   <= p0_rsp_err_d;
            p1_rsp_err_q   <= p1_rsp_err_d;
`endif
        end
    end

    assign bus.p0_ready_o     = grant0;
    assign bus.p1_ready_o     = grant1;
    assign bus.p0_rsp_valid_o = p0_rsp_valid_q;
    assign bus.p1_rsp_valid_o = p1_rsp_valid_q;
    assign bus.p0_rsp_rdata_o = p0_rsp_rdata_q;
    assign bus.p1_rsp_rdata_o = p1_rsp_rdata_q;
`ifdef SDMEM_ARB_ALIGN_CHECK_EN
    assign bus.p0_rsp_err_o   = p0_rsp_err_q;
    assign bus.p1_rsp_err_o   = p1_rsp_err_q;
`endif
    assign locked_o = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_sdmem_arbiter.sv
// Bench for sdmem_arbiter: directed scenarios plus a random phase, with a reference
// arbitration model and a read-data scoreboard. MAX_LOCK is set to 4 here.
module tb_sdmem_arbiter;
  localparam int DW = 32;
  localparam int MAX_LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdmem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  logic          mem_read_o, mem_write_o, locked_o;
  logic [1:0]    mem_size_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  sdmem_arbiter #(.DATA_WIDTH(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_size_o  (mem_size_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .locked_o    (locked_o)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- memory (physical model driven by DUT, reference model driven by bench)
  logic [7:0] phys_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] pa;
  assign pa = mem_addr_o[7:0];

  function automatic logic [7:0] init_byte(input int i);
    return (i == 16) ? 8'h80 : 8'(i * 37 + 11);
  endfunction

  // Loads sign-extend bytes and halves.
  always_comb begin
    case (mem_size_o)
      2'b00:   mem_rdata_i = {{24{phys_mem[pa][7]}}, phys_mem[pa]};
      2'b01:   mem_rdata_i = {{16{phys_mem[8'(pa + 8'd1)][7]}}, phys_mem[8'(pa + 8'd1)], phys_mem[pa]};
      default: mem_rdata_i = {phys_mem[8'(pa + 8'd3)], phys_mem[8'(pa + 8'd2)],
                              phys_mem[8'(pa + 8'd1)], phys_mem[pa]};
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) phys_mem[i] <= init_byte(i);
    end else if (mem_write_o) begin
      phys_mem[pa] <= mem_wdata_o[7:0];
      if (mem_size_o != 2'b00) phys_mem[8'(pa + 8'd1)] <= mem_wdata_o[15:8];
      if (mem_size_o[1]) begin
        phys_mem[8'(pa + 8'd2)] <= mem_wdata_o[23:16];
        phys_mem[8'(pa + 8'd3)] <= mem_wdata_o[31:24];
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_mem[a[7:0]];
    b1 = ref_mem[8'(a[7:0] + 8'd1)];
    b2 = ref_mem[8'(a[7:0] + 8'd2)];
    b3 = ref_mem[8'(a[7:0] + 8'd3)];
    case (sz)
      2'b00:   return {{24{b0[7]}}, b0};
      2'b01:   return {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    ref_mem[a[7:0]] = d[7:0];
    if (sz != 2'b00) ref_mem[8'(a[7:0] + 8'd1)] = d[15:8];
    if (sz[1]) begin
      ref_mem[8'(a[7:0] + 8'd2)] = d[23:16];
      ref_mem[8'(a[7:0] + 8'd3)] = d[31:24];
    end
  endtask

  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef SDMEM_ARB_ALIGN_CHECK_EN
    return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- scoreboard and reference arbitration model
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic pend0 = 1'b0, pend1 = 1'b0, epend0 = 1'b0, epend1 = 1'b0;
  logic m_locked = 1'b0;
  logic m_rr = 1'b0;
  int   m_cnt = 0;

  always @(negedge clk) begin : monitor
    logic g0, g1, mis, we, np0, np1, ne0, ne1;
    logic [1:0] sz;
    logic [31:0] a, wd, e;
    g0 = 1'b0; g1 = 1'b0; mis = 1'b0;
    np0 = 1'b0; np1 = 1'b0; ne0 = 1'b0; ne1 = 1'b0;

    check_eq("p0_rsp_valid", 32'(bus.p0_rsp_valid_o), 32'(pend0));
    check_eq("p1_rsp_valid", 32'(bus.p1_rsp_valid_o), 32'(pend1));
    if (pend0 && exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      check_eq("p0_rsp_rdata", bus.p0_rsp_rdata_o, e);
    end
    if (pend1 && exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      check_eq("p1_rsp_rdata", bus.p1_rsp_rdata_o, e);
    end
`ifdef SDMEM_ARB_ALIGN_CHECK_EN
    check_eq("p0_rsp_err", 32'(bus.p0_rsp_err_o), 32'(epend0));
    check_eq("p1_rsp_err", 32'(bus.p1_rsp_err_o), 32'(epend1));
`endif
    check_eq("locked_o", 32'(locked_o), 32'(m_locked));

    if (rst) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    end else if (m_locked) begin
      g1 = bus.p1_valid_i;
    end else if (bus.p0_valid_i && bus.p1_valid_i) begin
      g0 = ~m_rr;
      g1 = m_rr;
    end else begin
      g0 = bus.p0_valid_i;
      g1 = bus.p1_valid_i;
    end
    check_eq("p0_ready", 32'(bus.p0_ready_o), 32'(g0));
    check_eq("p1_ready", 32'(bus.p1_ready_o), 32'(g1));

    if (g0 || g1) begin
      we  = g1 ? bus.p1_we_i    : bus.p0_we_i;
      sz  = g1 ? bus.p1_size_i  : bus.p0_size_i;
      a   = g1 ? bus.p1_addr_i  : bus.p0_addr_i;
      wd  = g1 ? bus.p1_wdata_i : bus.p0_wdata_i;
      mis = is_mis(sz, a);
      check_eq("mem_read", 32'(mem_read_o), 32'(!mis && !we));
      check_eq("mem_write", 32'(mem_write_o), 32'(!mis && we));
      check_eq("mem_addr", mem_addr_o, mis ? 32'd0 : a);
      check_eq("mem_size", 32'(mem_size_o), mis ? 32'd0 : 32'(sz));
      check_eq("mem_wdata", mem_wdata_o, mis ? 32'd0 : wd);
      if (!mis && !we) begin
        if (g0) begin exp_q0.push_back(ref_load(a, sz)); np0 = 1'b1; end
        else    begin exp_q1.push_back(ref_load(a, sz)); np1 = 1'b1; end
      end
      if (!mis && we) ref_store(a, sz, wd);
      ne0 = g0 && mis;
      ne1 = g1 && mis;
    end else begin
      check_eq("mem_idle_rw", 32'({mem_read_o, mem_write_o}), 32'd0);
      check_eq("mem_idle_addr", mem_addr_o, 32'd0);
      check_eq("mem_idle_wdata", mem_wdata_o, 32'd0);
    end

    if (rst) begin
      m_locked = 1'b0; m_rr = 1'b0; m_cnt = 0;
    end else if (!m_locked) begin
      if (g0) m_rr = 1'b1;
      else if (g1) begin
        m_rr = 1'b0;
        if (bus.p1_lock_i) begin m_locked = 1'b1; m_cnt = 1; end
      end
    end else if (g1) begin
      m_cnt++;
      if (!bus.p1_lock_i || m_cnt >= MAX_LOCK) begin
        m_locked = 1'b0; m_cnt = 0; m_rr = 1'b0;
      end
    end
    pend0 = np0; pend1 = np1; epend0 = ne0; epend1 = ne1;
  end

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.p0_valid_i = 1'b0; bus.p0_we_i = 1'b0; bus.p0_size_i = 2'b00;
    bus.p0_addr_i = '0; bus.p0_wdata_i = '0;
    bus.p1_valid_i = 1'b0; bus.p1_we_i = 1'b0; bus.p1_size_i = 2'b00;
    bus.p1_addr_i = '0; bus.p1_wdata_i = '0; bus.p1_lock_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_p0(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.p0_valid_i = 1'b1; bus.p0_we_i = we; bus.p0_size_i = sz;
    bus.p0_addr_i = a; bus.p0_wdata_i = wd;
  endtask

  task automatic set_p1(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic lk);
    bus.p1_valid_i = 1'b1; bus.p1_we_i = we; bus.p1_size_i = sz;
    bus.p1_addr_i = a; bus.p1_wdata_i = wd; bus.p1_lock_i = lk;
  endtask

  task automatic expect_grants(input string tag, input logic r0, input logic r1, input logic lk);
    @(negedge clk);
    check_eq({tag, "_r0"}, 32'(bus.p0_ready_o), 32'(r0));
    check_eq({tag, "_r1"}, 32'(bus.p1_ready_o), 32'(r1));
    check_eq({tag, "_locked"}, 32'(locked_o), 32'(lk));
    tick();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic hold0, hold1;
    idle();
    do_reset();

    // Single byte read of 0x10 (0x80) returns sign-extended data one cycle later.
    set_p0(1'b0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    check_eq("t1_ready", 32'(bus.p0_ready_o), 32'd1);
    check_eq("t1_mem_read", 32'(mem_read_o), 32'd1);
    check_eq("t1_mem_addr", mem_addr_o, 32'h10);
    tick();
    idle();
    @(negedge clk);
    check_eq("t1_rsp_valid", 32'(bus.p0_rsp_valid_o), 32'd1);
    check_eq("t1_rdata", bus.p0_rsp_rdata_o, 32'hFFFFFF80);
    tick();

    // Contention from reset: p0, p1, p0, p1.
    do_reset();
    set_p0(1'b0, 2'b10, 32'h04, 32'h0);
    set_p1(1'b0, 2'b10, 32'h08, 32'h0, 1'b0);
    expect_grants("t2_c0", 1'b1, 1'b0, 1'b0);
    expect_grants("t2_c1", 1'b0, 1'b1, 1'b0);
    expect_grants("t2_c2", 1'b1, 1'b0, 1'b0);
    expect_grants("t2_c3", 1'b0, 1'b1, 1'b0);
    idle();
    tick();

    // Locked burst of three writes (lock 1,1,0) while p0 waits.
    do_reset();
    set_p0(1'b0, 2'b00, 32'h11, 32'h0);
    expect_grants("t3_pre", 1'b1, 1'b0, 1'b0);
    set_p0(1'b0, 2'b00, 32'h12, 32'h0);
    set_p1(1'b1, 2'b10, 32'h40, 32'h11111111, 1'b1);
    expect_grants("t3_b0", 1'b0, 1'b1, 1'b0);
    set_p1(1'b1, 2'b10, 32'h44, 32'h22222222, 1'b1);
    expect_grants("t3_b1", 1'b0, 1'b1, 1'b1);
    set_p1(1'b1, 2'b10, 32'h48, 32'h33333333, 1'b0);
    expect_grants("t3_b2", 1'b0, 1'b1, 1'b1);
    bus.p1_valid_i = 1'b0;
    expect_grants("t3_after", 1'b1, 1'b0, 1'b0);
    idle();
    tick();

    // Forced release after MAX_LOCK (4) locked grants.
    do_reset();
    set_p0(1'b0, 2'b00, 32'h13, 32'h0);
    expect_grants("t4_pre", 1'b1, 1'b0, 1'b0);
    set_p0(1'b0, 2'b10, 32'h30, 32'h0);
    for (int k = 0; k < 4; k++) begin
      set_p1(1'b1, 2'b10, 32'(32'h50 + 4 * k), 32'(32'hA0000000 + k), 1'b1);
      expect_grants("t4_lk", 1'b0, 1'b1, k != 0);
    end
    set_p1(1'b1, 2'b10, 32'h60, 32'hB0000005, 1'b1);
    expect_grants("t4_rel", 1'b1, 1'b0, 1'b0);
    bus.p0_valid_i = 1'b0;
    expect_grants("t4_res5", 1'b0, 1'b1, 1'b0);
    set_p1(1'b1, 2'b10, 32'h64, 32'hB0000006, 1'b1);
    expect_grants("t4_res6", 1'b0, 1'b1, 1'b1);
    idle();
    tick();

    // Write on p1, read back on p0.
    do_reset();
    set_p1(1'b1, 2'b10, 32'h20, 32'hDEADBEEF, 1'b0);
    expect_grants("t5_wr", 1'b0, 1'b1, 1'b0);
    bus.p1_valid_i = 1'b0;
    set_p0(1'b0, 2'b10, 32'h20, 32'h0);
    expect_grants("t5_rd", 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check_eq("t5_rsp_valid", 32'(bus.p0_rsp_valid_o), 32'd1);
    check_eq("t5_rdata", bus.p0_rsp_rdata_o, 32'hDEADBEEF);
    tick();

`ifdef SDMEM_ARB_ALIGN_CHECK_EN
    // Misaligned word read is accepted but not forwarded; error pulse follows.
    set_p0(1'b0, 2'b10, 32'h22, 32'h0);
    @(negedge clk);
    check_eq("t6_ready", 32'(bus.p0_ready_o), 32'd1);
    check_eq("t6_mem_read", 32'(mem_read_o), 32'd0);
    tick();
    idle();
    @(negedge clk);
    check_eq("t6_err", 32'(bus.p0_rsp_err_o), 32'd1);
    check_eq("t6_rsp_valid", 32'(bus.p0_rsp_valid_o), 32'd0);
    tick();
`endif

    // Reset while locked: ready forced low, state returns to ARB.
    do_reset();
    set_p1(1'b1, 2'b10, 32'h70, 32'h12345678, 1'b1);
    expect_grants("t7_lock", 1'b0, 1'b1, 1'b0);
    set_p1(1'b0, 2'b10, 32'h70, 32'h0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t7_rst_ready", 32'(bus.p1_ready_o), 32'd0);
    check_eq("t7_rst_memrd", 32'(mem_read_o), 32'd0);
    check_eq("t7_rst_locked_old", 32'(locked_o), 32'd1);
    tick();
    @(negedge clk);
    check_eq("t7_rst_locked", 32'(locked_o), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Random traffic, requests held until accepted.
    do_reset();
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold0) begin
        if ($urandom_range(0, 2) != 0)
          set_p0(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom());
        else
          bus.p0_valid_i = 1'b0;
      end
      if (!hold1) begin
        if ($urandom_range(0, 2) != 0)
          set_p1(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom(),
                 1'($urandom_range(0, 3) != 0));
        else
          bus.p1_valid_i = 1'b0;
      end
      @(negedge clk);
      hold0 = bus.p0_valid_i && !bus.p0_ready_o;
      hold1 = bus.p1_valid_i && !bus.p1_ready_o;
      tick();
    end
    idle();
    tick();
    tick();
    check_eq("q0_drained", 32'(exp_q0.size()), 32'd0);
    check_eq("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
